prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Upstream feeder for the 8-bit accumulator CPU core: streams a program image from the chip pins into the core's 32-byte memory through its write port.
- Checks a trailing checksum byte, then releases the core to run.
- Holds the core stalled (cpu_run=0) at all times except after a verified load.

Parameters:
- DEPTH, 32, number of image bytes written (memory size).
- AW, 5, memory address width (log2 DEPTH).
- DW, 8, data width.
- SYNC_STAGES, 2, synchronizer flops on each pin input (≥2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- pin_data  in  DW  image byte from pins; host holds it stable ≥SYNC_STAGES+2 cycles around each strobe rise.
- pin_strobe  in  1  asynchronous byte strobe; one rising edge per byte.
- pin_load  in  1  asynchronous load request; level high means load session.
- mem_we  out  1  one-cycle memory write pulse.
- mem_addr  out  AW  write address.
- mem_wdata  out  DW  write data.
- cpu_run  out  1  1 = core may execute; 0 = core held (PC at 0).
- busy  out  1  high in LOAD or CHECK.
- err  out  1  checksum failure flag (sticky until next load).
- byte_cnt  out  AW+1  bytes written this session (0..DEPTH).

Behaviour:
- Reset: state IDLE; all outputs 0; internal sum=0; sync flops=0.
- pin_data, pin_strobe and pin_load each pass through SYNC_STAGES flops. One extra flop provides edge detection. pin_data uses the same path, so it stays aligned with the strobe.
- Strobe latency: mem_we is high exactly SYNC_STAGES+1 clk edges after the first edge that samples pin_strobe high. The pulse lasts 1 cycle.
- States: IDLE, LOAD, CHECK, RUN, ERROR.
- Any state, load rise (synced) -> LOAD; byte_cnt=0, sum=0, err=0, cpu_run=0.
- LOAD, strobe rise -> mem_we=1, mem_addr=byte_cnt[AW-1:0], mem_wdata=byte. Then byte_cnt+=1 and sum=(sum+byte) mod 256.
- When byte_cnt reaches DEPTH -> CHECK. No write occurs on entering CHECK.
- CHECK, strobe rise with byte chk:
  - (sum+chk) mod 256 == 0 -> RUN; cpu_run=1 from the next cycle.
  - otherwise -> ERROR; err=1.
  - No memory write in either case.
- LOAD or CHECK, load fall -> IDLE (abort). Partial writes remain in memory; byte_cnt holds its value; cpu_run stays 0.
- RUN: cpu_run=1 until a load rise or reset. A load fall in RUN is ignored.
- IDLE, RUN, ERROR: strobe edges are ignored; mem_we stays 0.
- Load rise and strobe rise in the same cycle: load wins; the strobe is dropped and not written.
- Load fall and strobe rise in the same cycle in LOAD: abort wins; no write.
- byte_cnt never exceeds DEPTH. mem_addr wraps are impossible by construction.
- Reset mid-load: immediate return to reset values; cpu_run=0. Memory contents are not touched by this block.
- mem_addr and mem_wdata are registered; they hold their last value when mem_we=0.

Decomposition:
- Shared package prog_loader_pkg:
  - state enum (IDLE, LOAD, CHECK, RUN, ERROR).
  - constants DEPTH and DW shared with the CPU core.
- Sub-module pin_sync: SYNC_STAGES synchronizer plus rise/fall pulse outputs, parameterized width. Instantiated for strobe/load (1 bit) and data (DW).

Test Plan:
- Reset: hold rst_n=0, toggle pins -> all outputs 0, state IDLE; release -> still idle, no writes.
- Full load:
  - Stimulus: load=1; bytes 0x00..0x1F; chk=0x10 (sum 496 mod 256 = 240).
  - Expect: 32 writes with addr=data=0..31 in order; byte_cnt=32; cpu_run=1; err=0; busy=0.
  - Expect: each mem_we exactly 3 edges after strobe sampled high.
- Bad checksum: same image, chk=0x00 -> state ERROR, err=1, cpu_run=0; a further strobe -> no write.
- Abort: 10 bytes then load=0 -> IDLE, byte_cnt=10; next strobe -> no write. Then load=1 -> byte_cnt=0 and writes restart at addr 0.
- Reload from RUN: after a good load, pulse load 0->1 -> cpu_run drops the cycle after the synced rise. A new image of 0xAA x32 with chk=0xC0 -> RUN again.
- Collisions and reset:
  - Load rise coincident with strobe rise -> no write, byte_cnt=0.
  - rst_n low after 5 bytes -> outputs 0 immediately (asynchronous), state IDLE.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and sizes for the program loader and the accumulator core it feeds.
package prog_loader_pkg;

  localparam int DEPTH       = 32;
  localparam int AW          = $clog2(DEPTH);
  localparam int DW          = 8;
  localparam int SYNC_STAGES = 2;

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_RUN,
    ST_ERROR
  } state_e;

  function automatic logic is_busy(input state_e s);
    return (s == ST_LOAD) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/prog_loader_pin_sync.sv
// Multi-flop synchronizer for asynchronous pins with registered rise/fall pulses.
// level is delayed by the edge flop so it lines up with the pulses.
module pin_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] level,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [STAGES-1:0][W-1:0] sync_q, sync_d;
  logic [W-1:0] edge_q, edge_d;
  logic [W-1:0] rise_q, rise_d;
  logic [W-1:0] fall_q, fall_d;

  always_comb begin
    sync_d    = '0;
    sync_d[0] = d_in;
    for (int i = 1; i < STAGES; i++) sync_d[i] = sync_q[i-1];
    edge_d = sync_q[STAGES-1];
    rise_d = sync_q[STAGES-1] & ~edge_q;
    fall_d = ~sync_q[STAGES-1] & edge_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level = edge_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/prog_loader.sv
// Streams a program image from the pins into the core memory, verifies the
// trailing checksum byte and only then releases the core.
//
// state    | meaning
// ST_IDLE  | no session; core held
// ST_LOAD  | writing image bytes to memory
// ST_CHECK | waiting for checksum byte
// ST_RUN   | image verified; core running
// ST_ERROR | checksum mismatch; core held
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] pin_data,
  input  logic          pin_strobe,
  input  logic          pin_load,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          cpu_run,
  output logic          busy,
  output logic          err,
  output logic [AW:0]   byte_cnt
);

  logic          load_lvl, load_rise, load_fall;
  logic          strb_lvl, strb_rise, strb_fall;
  logic [DW-1:0] data_lvl, data_rise, data_fall;

  pin_sync #(.W(1), .STAGES(SYNC_STAGES)) u_sync_load (
    .clk(clk), .rst_n(rst_n), .d_in(pin_load),
    .level(load_lvl), .rise(load_rise), .fall(load_fall)
  );

  pin_sync #(.W(1), .STAGES(SYNC_STAGES)) u_sync_strb (
    .clk(clk), .rst_n(rst_n), .d_in(pin_strobe),
    .level(strb_lvl), .rise(strb_rise), .fall(strb_fall)
  );

  pin_sync #(.W(DW), .STAGES(SYNC_STAGES)) u_sync_data (
    .clk(clk), .rst_n(rst_n), .d_in(pin_data),
    .level(data_lvl), .rise(data_rise), .fall(data_fall)
  );

  state_e        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [DW-1:0] sum_q, sum_d, chk_sum;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d, run_q, run_d, busy_q, busy_d, err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    chk_sum = sum_q + data_lvl;

    // A load rise restarts the session from any state and swallows a coincident strobe.
    if (load_rise) begin
      state_d = ST_LOAD;
      cnt_d   = '0;
      sum_d   = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (load_fall) begin
            state_d = ST_IDLE;
          end else if (strb_rise) begin
            we_d    = 1'b1;
            addr_d  = cnt_q[AW-1:0];
            wdata_d = data_lvl;
            cnt_d   = cnt_q + 1'b1;
            sum_d   = chk_sum;
            if (cnt_d == CNT_FULL) state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (load_fall) begin
            state_d = ST_IDLE;
          end else if (strb_rise) begin
            if (chk_sum == '0) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_ERROR;
              err_d   = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    run_d  = (state_d == ST_RUN);
    busy_d = is_busy(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      run_q   <= run_d;
      busy_q  <= busy_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_run   = run_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign byte_cnt  = cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: full load, bad checksum, abort, reload,
// collisions and asynchronous reset.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pin_data;
  logic       pin_strobe, pin_load;
  logic       mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_run, busy, err;
  logic [5:0] byte_cnt;

  logic [22:0] outs;
  int vectors = 0;
  int fails   = 0;
  int we_total = 0;

  prog_loader dut (
    .clk(clk), .rst_n(rst_n), .pin_data(pin_data), .pin_strobe(pin_strobe),
    .pin_load(pin_load), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_run(cpu_run), .busy(busy), .err(err),
    .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  assign outs = {mem_we, mem_addr, mem_wdata, cpu_run, busy, err, byte_cnt};

  always @(negedge clk) if (mem_we === 1'b1) we_total++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Strobe one byte; mem_we must appear only on the 4th falling edge after the
  // strobe is raised (3 rising edges after the first sampling edge).
  task automatic send_byte(input logic [7:0] b, input bit exp_we, input logic [4:0] exp_addr);
    logic [6:1] hist;
    logic [4:0] a;
    logic [7:0] d;
    hist = '0;
    a = '0;
    d = '0;
    pin_data = b;
    @(negedge clk);
    pin_strobe = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      hist[n] = mem_we;
      if (n == 4) begin
        a = mem_addr;
        d = mem_wdata;
      end
    end
    check("we_timing", 32'(hist), exp_we ? 32'h8 : 32'h0);
    if (exp_we) begin
      check("addr", 32'(a), 32'(exp_addr));
      check("wdata", 32'(d), 32'(b));
    end
    pin_strobe = 1'b0;
    idle(4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] run_hist;
    logic [6:1] coll_hist;

    rst_n = 1'b0; pin_data = 8'h00; pin_strobe = 1'b0; pin_load = 1'b0;

    // Reset held while pins toggle
    idle(2);
    pin_load = 1'b1; pin_data = 8'hA5;
    for (int i = 0; i < 6; i++) begin
      pin_strobe = ~pin_strobe;
      @(negedge clk);
    end
    check("reset_outs_a", 32'(outs), 32'h0);
    pin_strobe = 1'b1; pin_data = 8'h3C;
    idle(4);
    check("reset_outs_b", 32'(outs), 32'h0);
    pin_load = 1'b0; pin_strobe = 1'b0; pin_data = 8'h00;
    idle(2);
    rst_n = 1'b1;
    idle(8);
    check("post_reset_outs", 32'(outs), 32'h0);
    check("post_reset_no_we", 32'(we_total), 32'd0);

    // Full good load
    pin_load = 1'b1;
    idle(6);
    check("load_busy", 32'(busy), 32'd1);
    check("load_cnt0", 32'(byte_cnt), 32'd0);
    for (int i = 0; i < 32; i++) send_byte(8'(i), 1'b1, 5'(i));
    check("full_cnt", 32'(byte_cnt), 32'd32);
    check("check_busy", 32'(busy), 32'd1);
    check("check_run0", 32'(cpu_run), 32'd0);
    send_byte(8'h10, 1'b0, 5'd0);
    check("good_run", 32'(cpu_run), 32'd1);
    check("good_err", 32'(err), 32'd0);
    check("good_busy", 32'(busy), 32'd0);
    check("good_cnt", 32'(byte_cnt), 32'd32);
    check("good_we_total", 32'(we_total), 32'd32);
    send_byte(8'h01, 1'b0, 5'd0);
    check("run_strobe_ignored", 32'(cpu_run), 32'd1);

    // Reload from RUN: load fall ignored, load rise drops cpu_run
    pin_load = 1'b0;
    idle(6);
    check("run_fall_ignored", 32'(cpu_run), 32'd1);
    pin_load = 1'b1;
    run_hist = '0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      run_hist[n-1] = cpu_run;
    end
    check("reload_run_drop", 32'(run_hist), 32'h7);
    idle(2);
    check("reload_cnt0", 32'(byte_cnt), 32'd0);
    for (int i = 0; i < 32; i++) send_byte(8'hAA, 1'b1, 5'(i));
    send_byte(8'hC0, 1'b0, 5'd0);
    check("reload_run", 32'(cpu_run), 32'd1);
    check("reload_err", 32'(err), 32'd0);

    // Bad checksum
    pin_load = 1'b0;
    idle(6);
    pin_load = 1'b1;
    idle(6);
    for (int i = 0; i < 32; i++) send_byte(8'(i), 1'b1, 5'(i));
    send_byte(8'h00, 1'b0, 5'd0);
    check("bad_err", 32'(err), 32'd1);
    check("bad_run", 32'(cpu_run), 32'd0);
    check("bad_busy", 32'(busy), 32'd0);
    send_byte(8'h5A, 1'b0, 5'd0);
    pin_load = 1'b0;
    idle(6);
    check("err_sticky", 32'(err), 32'd1);

    // Abort after 10 bytes, then restart
    pin_load = 1'b1;
    idle(6);
    check("restart_err_clr", 32'(err), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 10; i++) send_byte(8'h40 + 8'(i), 1'b1, 5'(i));
    pin_load = 1'b0;
    idle(6);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cnt", 32'(byte_cnt), 32'd10);
    check("abort_run", 32'(cpu_run), 32'd0);
    send_byte(8'h33, 1'b0, 5'd0);
    pin_load = 1'b1;
    idle(6);
    check("again_cnt0", 32'(byte_cnt), 32'd0);
    send_byte(8'h55, 1'b1, 5'd0);
    check("again_cnt1", 32'(byte_cnt), 32'd1);

    // Load rise coincident with strobe rise
    pin_load = 1'b0;
    idle(6);
    pin_data = 8'h77;
    @(negedge clk);
    pin_load = 1'b1;
    pin_strobe = 1'b1;
    coll_hist = '0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      coll_hist[n] = mem_we;
    end
    check("coll_no_we", 32'(coll_hist), 32'h0);
    check("coll_cnt", 32'(byte_cnt), 32'd0);
    check("coll_busy", 32'(busy), 32'd1);
    pin_strobe = 1'b0;
    idle(4);

    // Asynchronous reset after 5 bytes
    for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i), 1'b1, 5'(i));
    check("pre_rst_cnt", 32'(byte_cnt), 32'd5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst_outs", 32'(outs), 32'h0);
    pin_load = 1'b0;
    idle(3);
    check("rst_hold_outs", 32'(outs), 32'h0);
    rst_n = 1'b1;
    idle(6);
    check("rst_release_outs", 32'(outs), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
